// File: rtl/scpad_row_packer_if.sv
// Handshake bundle between the DRAM beat source, the row packer and the SRAM row-write port.
// The DUT uses the slave modport; the beat/command source and the SRAM side use master.
interface scpad_row_packer_if #(
  parameter int BEAT_BITS     = 64,
  parameter int NUM_COLS      = 32,
  parameter int ELEM_BITS     = 16,
  parameter int ROW_IDX_WIDTH = 14,
  parameter int MAX_TILE_SIZE = 32
);
  localparam int CNT_W = $clog2(MAX_TILE_SIZE) + 1;

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [ROW_IDX_WIDTH-1:0]      cmd_base_row;
  logic [CNT_W-1:0]              cmd_num_rows;
  logic [CNT_W-1:0]              cmd_num_cols;
  logic                          beat_valid;
  logic                          beat_ready;
  logic [BEAT_BITS-1:0]          beat_data;
  logic                          wr_valid;
  logic                          wr_ready;
  logic [ROW_IDX_WIDTH-1:0]      wr_row;
  logic [NUM_COLS*ELEM_BITS-1:0] wr_data;
  logic [NUM_COLS-1:0]           wr_mask;

  modport master (
    output cmd_valid, cmd_base_row, cmd_num_rows, cmd_num_cols,
    output beat_valid, beat_data, wr_ready,
    input  cmd_ready, beat_ready, wr_valid, wr_row, wr_data, wr_mask
  );

  modport slave (
    input  cmd_valid, cmd_base_row, cmd_num_rows, cmd_num_cols,
    input  beat_valid, beat_data, wr_ready,
    output cmd_ready, beat_ready, wr_valid, wr_row, wr_data, wr_mask
  );
endinterface

// File: rtl/scpad_row_packer.sv
// Packs DRAM beats into masked scratchpad row writes, one write per tile row at consecutive slots.
// SCPAD_PACKER_DBUF_EN: ping-pong row buffers so the next row fills while a row waits on wr_ready.
module scpad_row_packer #(
  parameter int BEAT_BITS     = 64,
  parameter int NUM_COLS      = 32,
  parameter int ELEM_BITS     = 16,
  parameter int ROW_IDX_WIDTH = 14,
  parameter int MAX_TILE_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  scpad_row_packer_if.slave io,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int EPB      = BEAT_BITS / ELEM_BITS;
  localparam int ROW_BITS = NUM_COLS * ELEM_BITS;
  localparam int CNT_W    = $clog2(MAX_TILE_SIZE) + 1;
  localparam int PTR_W    = $clog2(NUM_COLS) + 1;
`ifdef SCPAD_PACKER_DBUF_EN
  localparam int   NBUF = 2;
  localparam logic ALT  = 1'b1;
`else
  localparam int   NBUF = 1;
  localparam logic ALT  = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

  state_t                             state_q, state_d;
  logic [ROW_IDX_WIDTH-1:0]           base_q, base_d;
  logic [CNT_W-1:0]                   rows_q, rows_d;
  logic [CNT_W-1:0]                   cols_q, cols_d;
  logic [CNT_W-1:0]                   row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]                   fill_cnt_q, fill_cnt_d;
  logic [PTR_W-1:0]                   col_ptr_q, col_ptr_d;
  logic [NBUF-1:0][ROW_BITS-1:0]      buf_q, buf_d;
  logic [NBUF-1:0]                    full_q, full_d;
  logic                               fsel_q, fsel_d;
  logic                               esel_q, esel_d;
  logic                               done_q, done_d;
  logic                               err_q, err_d;

  logic cmd_hs, beat_hs, wr_hs, cmd_bad;

  assign cmd_hs  = io.cmd_valid && io.cmd_ready;
  assign beat_hs = io.beat_valid && io.beat_ready;
  assign wr_hs   = io.wr_valid && io.wr_ready;
  assign cmd_bad = (io.cmd_num_rows == '0) || (io.cmd_num_rows > CNT_W'(MAX_TILE_SIZE)) ||
                   (io.cmd_num_cols == '0) || (io.cmd_num_cols > CNT_W'(MAX_TILE_SIZE));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    row_cnt_d  = row_cnt_q;
    fill_cnt_d = fill_cnt_q;
    col_ptr_d  = col_ptr_q;
    buf_d      = buf_q;
    full_d     = full_q;
    fsel_d     = fsel_q;
    esel_d     = esel_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (cmd_hs) begin
      if (cmd_bad) begin
        err_d = 1'b1;
      end else begin
        base_d     = io.cmd_base_row;
        rows_d     = io.cmd_num_rows;
        cols_d     = io.cmd_num_cols;
        row_cnt_d  = '0;
        fill_cnt_d = '0;
        col_ptr_d  = '0;
        fsel_d     = 1'b0;
        esel_d     = 1'b0;
        state_d    = FILL;
      end
    end

    // Emit and fill never target the same buffer: a full buffer blocks beats.
    if (wr_hs) begin
      buf_d[esel_q]  = '0;
      full_d[esel_q] = 1'b0;
      esel_d         = esel_q ^ ALT;
      row_cnt_d      = row_cnt_q + CNT_W'(1);
      if (row_cnt_q == rows_q - CNT_W'(1)) done_d = 1'b1;
    end

    if (beat_hs) begin
      // col_ptr is a multiple of EPB, so lane l always takes element l%EPB of the beat.
      for (int l = 0; l < NUM_COLS; l++) begin
        if ((l / EPB) == (int'(col_ptr_q) / EPB) && l < int'(cols_q))
          buf_d[fsel_q][l*ELEM_BITS +: ELEM_BITS] = io.beat_data[(l % EPB)*ELEM_BITS +: ELEM_BITS];
      end
      if (int'(col_ptr_q) + EPB >= int'(cols_q)) begin
        full_d[fsel_q] = 1'b1;
        fsel_d         = fsel_q ^ ALT;
        fill_cnt_d     = fill_cnt_q + CNT_W'(1);
        col_ptr_d      = '0;
      end else begin
        col_ptr_d = col_ptr_q + PTR_W'(EPB);
      end
    end

    if (state_q != IDLE) state_d = done_d ? IDLE : ((|full_d) ? EMIT : FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      row_cnt_q  <= '0;
      fill_cnt_q <= '0;
      col_ptr_q  <= '0;
      buf_q      <= '0;
      full_q     <= '0;
      fsel_q     <= 1'b0;
      esel_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      row_cnt_q  <= row_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      col_ptr_q  <= col_ptr_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      fsel_q     <= fsel_d;
      esel_q     <= esel_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  logic [NUM_COLS-1:0] mask;
  always_comb begin
    mask = '0;
    for (int l = 0; l < NUM_COLS; l++) mask[l] = io.wr_valid && (l < int'(cols_q));
  end

  assign io.cmd_ready  = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign io.beat_ready = (state_q != IDLE) && !full_q[fsel_q] && (fill_cnt_q < rows_q);
  assign io.wr_valid   = (state_q != IDLE) && full_q[esel_q];
  assign io.wr_row     = io.wr_valid ? base_q + ROW_IDX_WIDTH'(row_cnt_q) : '0;
  assign io.wr_data    = io.wr_valid ? buf_q[esel_q] : '0;
  assign io.wr_mask    = mask;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_scpad_row_packer.sv
// Randomized bench for scpad_row_packer: expected rows are rebuilt from the beats sent,
// using plain lane arithmetic (row r, lane l comes from beat r*ceil(cols/4)+l/4, element l%4).
module tb_scpad_row_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, done, err;
  int   pass = 0, total = 0, cyc = 0;

`ifdef SCPAD_PACKER_DBUF_EN
  localparam int STALL_BEATS = 8;
`else
  localparam int STALL_BEATS = 0;
`endif

  scpad_row_packer_if bus();
  scpad_row_packer dut (.clk(clk), .rst(rst), .io(bus), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0]  beats[$];
  logic [13:0]  obs_row[$];
  logic [511:0] obs_data[$];
  logic [31:0]  obs_mask[$];
  int           obs_cyc[$];
  int           beat_cyc[$];
  int n_cons, n_done, n_err, done_cyc, n_unstable, stall_beats, saw_bready, both_seen, timed_out;

  function automatic logic [511:0] exp_data(int r, int cols);
    int bpr;
    logic [63:0] b;
    bpr = (cols + 3) / 4;
    exp_data = '0;
    for (int l = 0; l < cols; l++) begin
      b = beats[r*bpr + l/4];
      exp_data[l*16 +: 16] = b[(l%4)*16 +: 16];
    end
  endfunction

  function automatic logic [31:0] exp_mask(int cols);
    logic [63:0] m;
    m = (64'd1 << cols) - 64'd1;
    return m[31:0];
  endfunction

  // Drives one command plus its beats and records every write; no comparisons here.
  task automatic run_tile(input logic [13:0] base, input int rows, input int cols, input int nbeats,
                          input int bprob, input int wprob, input int hold, input int budget);
    bit sent = 0, stalled = 0;
    int tail = 0, ncyc = 0, hold_left = hold;
    logic [13:0] p_row; logic [511:0] p_data; logic [31:0] p_mask;
    beats.delete(); obs_row.delete(); obs_data.delete(); obs_mask.delete();
    obs_cyc.delete(); beat_cyc.delete();
    for (int i = 0; i < nbeats; i++) beats.push_back({$urandom, $urandom});
    n_cons = 0; n_done = 0; n_err = 0; done_cyc = -1; n_unstable = 0;
    stall_beats = 0; saw_bready = 0; both_seen = 0; timed_out = 0;
    p_row = '0; p_data = '0; p_mask = '0;
    while (tail < 3) begin
      @(negedge clk);
      bus.cmd_valid    = !sent && tail == 0;
      bus.cmd_base_row = base;
      bus.cmd_num_rows = 6'(rows);
      bus.cmd_num_cols = 6'(cols);
      bus.beat_valid   = (n_cons < nbeats) && (int'($urandom_range(99)) < bprob);
      bus.beat_data    = (n_cons < nbeats) ? beats[n_cons] : 64'h0;
      if (hold_left > 0 && bus.wr_valid) begin
        bus.wr_ready = 1'b0;
        hold_left--;
      end else begin
        bus.wr_ready = int'($urandom_range(99)) < wprob;
      end
      #1;
      if (stalled && (!bus.wr_valid || bus.wr_row !== p_row || bus.wr_data !== p_data ||
                      bus.wr_mask !== p_mask)) n_unstable++;
      stalled = bus.wr_valid && !bus.wr_ready;
      p_row = bus.wr_row; p_data = bus.wr_data; p_mask = bus.wr_mask;
      if (bus.cmd_valid && bus.cmd_ready) sent = 1;
      if (bus.beat_ready) saw_bready = 1;
      if (bus.beat_valid && bus.beat_ready) begin
        beat_cyc.push_back(cyc);
        n_cons++;
        if (bus.wr_valid && !bus.wr_ready) stall_beats++;
      end
      if (bus.wr_valid && bus.wr_ready) begin
        obs_row.push_back(bus.wr_row); obs_data.push_back(bus.wr_data);
        obs_mask.push_back(bus.wr_mask); obs_cyc.push_back(cyc);
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) n_err++;
      if (done && err) both_seen = 1;
      if (n_done > 0 || n_err > 0) tail++;
      ncyc++;
      if (ncyc >= budget) begin timed_out = 1; tail = 3; end
    end
    bus.cmd_valid = 1'b0; bus.beat_valid = 1'b0; bus.wr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready); else pass++;
    total++; if ({bus.beat_ready, bus.wr_valid, busy, done, err} !== 5'b0)
      $display("FAIL reset_flags got %b exp 00000", {bus.beat_ready, bus.wr_valid, busy, done, err}); else pass++;
    total++; if ({bus.wr_row, bus.wr_mask} !== 46'h0)
      $display("FAIL reset_row_mask got %h/%h exp 0/0", bus.wr_row, bus.wr_mask); else pass++;
    total++; if (bus.wr_data !== 512'h0) $display("FAIL reset_data got %h exp 0", bus.wr_data); else pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_width();
    run_tile(14'h100, 2, 32, 16, 100, 100, 0, 500);
    total++; if (timed_out !== 0) $display("FAIL full_timeout got %0d exp 0", timed_out); else pass++;
    total++; if (obs_row.size() !== 2) $display("FAIL full_nwr got %0d exp 2", obs_row.size()); else pass++;
    for (int r = 0; r < 2 && r < obs_row.size(); r++) begin
      total++; if (obs_row[r] !== 14'(14'h100 + r)) $display("FAIL full_row%0d got %h exp %h", r, obs_row[r], 14'(14'h100 + r)); else pass++;
      total++; if (obs_mask[r] !== 32'hFFFF_FFFF) $display("FAIL full_mask%0d got %h exp ffffffff", r, obs_mask[r]); else pass++;
      total++; if (obs_data[r] !== exp_data(r, 32)) $display("FAIL full_data%0d got %h exp %h", r, obs_data[r], exp_data(r, 32)); else pass++;
      if (beat_cyc.size() == 16) begin
        total++; if (obs_cyc[r] !== beat_cyc[8*r+7] + 1)
          $display("FAIL full_latency%0d got %0d exp %0d", r, obs_cyc[r], beat_cyc[8*r+7] + 1); else pass++;
      end
    end
    total++; if (n_done !== 1) $display("FAIL full_ndone got %0d exp 1", n_done); else pass++;
    if (obs_cyc.size() == 2) begin
      total++; if (done_cyc !== obs_cyc[1] + 1) $display("FAIL full_done_cyc got %0d exp %0d", done_cyc, obs_cyc[1] + 1); else pass++;
    end
  endtask

  task automatic test_partial_cols();
    run_tile(14'd5, 1, 6, 2, 80, 80, 0, 500);
    total++; if (obs_row.size() !== 1) $display("FAIL part_nwr got %0d exp 1", obs_row.size()); else pass++;
    total++; if (n_cons !== 2) $display("FAIL part_beats got %0d exp 2", n_cons); else pass++;
    if (obs_row.size() == 1) begin
      total++; if (obs_row[0] !== 14'd5) $display("FAIL part_row got %h exp 5", obs_row[0]); else pass++;
      total++; if (obs_mask[0] !== 32'h3F) $display("FAIL part_mask got %h exp 3f", obs_mask[0]); else pass++;
      total++; if (obs_data[0][63:0] !== beats[0]) $display("FAIL part_a got %h exp %h", obs_data[0][63:0], beats[0]); else pass++;
      total++; if (obs_data[0][95:64] !== beats[1][31:0]) $display("FAIL part_b got %h exp %h", obs_data[0][95:64], beats[1][31:0]); else pass++;
      total++; if (obs_data[0][511:96] !== 416'h0) $display("FAIL part_hi got %h exp 0", obs_data[0][511:96]); else pass++;
    end
  endtask

  task automatic test_wrap();
    logic [13:0] exp_r[3];
    exp_r[0] = 14'h3FFF; exp_r[1] = 14'h0000; exp_r[2] = 14'h0001;
    run_tile(14'h3FFF, 3, 4, 3, 70, 60, 0, 500);
    total++; if (obs_row.size() !== 3) $display("FAIL wrap_nwr got %0d exp 3", obs_row.size()); else pass++;
    for (int r = 0; r < 3 && r < obs_row.size(); r++) begin
      total++; if (obs_row[r] !== exp_r[r]) $display("FAIL wrap_row%0d got %h exp %h", r, obs_row[r], exp_r[r]); else pass++;
      total++; if (obs_data[r] !== exp_data(r, 4)) $display("FAIL wrap_data%0d got %h exp %h", r, obs_data[r], exp_data(r, 4)); else pass++;
    end
    total++; if (n_done !== 1) $display("FAIL wrap_ndone got %0d exp 1", n_done); else pass++;
  endtask

  task automatic test_illegal();
    int bad_r[2], bad_c[2];
    bad_r[0] = 0; bad_c[0] = 8; bad_r[1] = 1; bad_c[1] = 33;
    for (int k = 0; k < 2; k++) begin
      run_tile(14'h40, bad_r[k], bad_c[k], 4, 100, 100, 0, 100);
      total++; if (n_err !== 1) $display("FAIL ill%0d_err got %0d exp 1", k, n_err); else pass++;
      total++; if (obs_row.size() !== 0) $display("FAIL ill%0d_wr got %0d exp 0", k, obs_row.size()); else pass++;
      total++; if (saw_bready !== 0 || n_cons !== 0)
        $display("FAIL ill%0d_beats got ready=%0d consumed=%0d exp 0/0", k, saw_bready, n_cons); else pass++;
      total++; if (n_done !== 0) $display("FAIL ill%0d_done got %0d exp 0", k, n_done); else pass++;
    end
    run_tile(14'h200, 2, 12, 6, 90, 90, 0, 500);
    total++; if (obs_row.size() !== 2 || n_err !== 0)
      $display("FAIL ill_recover got nwr=%0d err=%0d exp 2/0", obs_row.size(), n_err); else pass++;
    for (int r = 0; r < 2 && r < obs_row.size(); r++) begin
      total++; if (obs_data[r] !== exp_data(r, 12) || obs_mask[r] !== 32'hFFF || obs_row[r] !== 14'(14'h200 + r))
        $display("FAIL ill_recover_row%0d got %h/%h/%h", r, obs_row[r], obs_mask[r], obs_data[r]); else pass++;
    end
  endtask

  task automatic test_backpressure();
    run_tile(14'h80, 2, 32, 16, 100, 100, 12, 500);
    total++; if (n_unstable !== 0) $display("FAIL bp_stable got %0d exp 0", n_unstable); else pass++;
    total++; if (stall_beats !== STALL_BEATS) $display("FAIL bp_stall_beats got %0d exp %0d", stall_beats, STALL_BEATS); else pass++;
    total++; if (obs_row.size() !== 2) $display("FAIL bp_nwr got %0d exp 2", obs_row.size()); else pass++;
    for (int r = 0; r < 2 && r < obs_row.size(); r++) begin
      total++; if (obs_data[r] !== exp_data(r, 32) || obs_row[r] !== 14'(14'h80 + r))
        $display("FAIL bp_row%0d got %h/%h exp %h/%h", r, obs_row[r], obs_data[r], 14'(14'h80 + r), exp_data(r, 32)); else pass++;
    end
  endtask

  task automatic test_reset_mid();
    int got = 0, n = 0, bad = 0;
    bit sent = 0;
    while (got < 3 && n < 50) begin
      @(negedge clk);
      bus.cmd_valid = !sent; bus.cmd_base_row = 14'h20; bus.cmd_num_rows = 6'd1; bus.cmd_num_cols = 6'd32;
      bus.beat_valid = sent; bus.beat_data = {$urandom, $urandom}; bus.wr_ready = 1'b1;
      #1;
      if (bus.cmd_valid && bus.cmd_ready) sent = 1;
      if (bus.beat_valid && bus.beat_ready) got++;
      n++;
    end
    total++; if (got !== 3) $display("FAIL rstmid_beats got %0d exp 3", got); else pass++;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.beat_valid = 1'b0; rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || bus.cmd_ready !== 1'b1)
      $display("FAIL rstmid_state got busy=%b cmd_ready=%b exp 0/1", busy, bus.cmd_ready); else pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      bus.beat_valid = 1'b1; bus.wr_ready = 1'b1;
      #1;
      if (bus.wr_valid || bus.beat_ready) bad++;
    end
    bus.beat_valid = 1'b0;
    total++; if (bad !== 0) $display("FAIL rstmid_quiet got %0d exp 0", bad); else pass++;
    run_tile(14'h21, 1, 32, 8, 80, 80, 0, 500);
    total++; if (obs_row.size() !== 1) $display("FAIL rstmid_fresh_nwr got %0d exp 1", obs_row.size()); else pass++;
    if (obs_row.size() == 1) begin
      total++; if (obs_data[0] !== exp_data(0, 32) || obs_row[0] !== 14'h21)
        $display("FAIL rstmid_fresh got %h/%h exp 21/%h", obs_row[0], obs_data[0], exp_data(0, 32)); else pass++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [13:0] base;
      int rows, cols;
      base = 14'($urandom);
      rows = int'($urandom_range(4, 1));
      cols = int'($urandom_range(32, 1));
      run_tile(base, rows, cols, rows * ((cols + 3) / 4),
               int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0, 2000);
      total++; if (obs_row.size() !== rows || n_done !== 1 || n_err !== 0 || timed_out !== 0)
        $display("FAIL rnd%0d_summary got nwr=%0d done=%0d err=%0d to=%0d exp %0d/1/0/0",
                 it, obs_row.size(), n_done, n_err, timed_out, rows); else pass++;
      total++; if (n_unstable !== 0 || both_seen !== 0)
        $display("FAIL rnd%0d_protocol got unstable=%0d both=%0d exp 0/0", it, n_unstable, both_seen); else pass++;
      for (int r = 0; r < rows && r < obs_row.size(); r++) begin
        total++; if (obs_row[r] !== 14'(base + r) || obs_mask[r] !== exp_mask(cols) || obs_data[r] !== exp_data(r, cols))
          $display("FAIL rnd%0d_row%0d got %h/%h/%h exp %h/%h/%h", it, r, obs_row[r], obs_mask[r], obs_data[r],
                   14'(base + r), exp_mask(cols), exp_data(r, cols)); else pass++;
      end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_base_row = '0; bus.cmd_num_rows = '0; bus.cmd_num_cols = '0;
    bus.beat_valid = 1'b0; bus.beat_data = '0; bus.wr_ready = 1'b0;
    test_reset();
    test_full_width();
    test_partial_cols();
    test_wrap();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
